// File: rtl/ball_pkg.sv
// Shared types and constants for the ball position engine.
// Holds the FSM state encoding, the per-axis move direction encoding,
// the default wall code and a small helper used by the tilt debounce.
package ball_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PROBE_X = 3'd1,
    CHECK_X = 3'd2,
    PROBE_Y = 3'd3,
    CHECK_Y = 3'd4
  } ball_state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_INC  = 2'd1,
    DIR_DEC  = 2'd2
  } ball_dir_t;

  localparam int WALL_CODE_DEFAULT = 2;

  // A direction only survives when it matches the one seen on the previous tick.
  function automatic ball_dir_t debounce_dir(input ball_dir_t cur, input ball_dir_t prev);
    return (cur == prev) ? cur : DIR_NONE;
  endfunction

endpackage

// File: rtl/ball_tick_gen.sv
// Periodic one-cycle tick generator shared by the game blocks.
// The counter runs 0..TOP_CNT and the tick is high on the wrap cycle.
// SIMULATE shortens the period to SIMULATE_FREQUENCY_CNT+1 cycles.
module ball_tick_gen #(
  parameter int CLK_FREQUENCY_HZ       = 100000000,
  parameter int UPDATE_FREQUENCY_HZ    = 5,
  parameter int SIMULATE               = 0,
  parameter int SIMULATE_FREQUENCY_CNT = 5
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int TOP_CNT = (SIMULATE != 0) ? SIMULATE_FREQUENCY_CNT
                                           : (CLK_FREQUENCY_HZ / UPDATE_FREQUENCY_HZ) - 1;
  localparam int CNT_W = (TOP_CNT > 0) ? $clog2(TOP_CNT + 1) : 1;
  localparam logic [CNT_W-1:0] TOP_VAL = CNT_W'(TOP_CNT);

  logic [CNT_W-1:0] cnt;

  // Free-running counter that wraps back to zero after the terminal count.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == TOP_VAL) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == TOP_VAL);

endmodule

// File: rtl/ball_mover.sv
// Accelerometer-driven ball position engine for the labyrinth game.
// On every update tick each axis gets a direction from its tilt sample;
// the candidate cell is probed in the world map and the move is committed
// only if that cell is not a wall. X is resolved first, then Y using the
// already-updated X, so diagonal moves are two orthogonal steps.
// Optional build macro: BALL_TILT_DEBOUNCE_EN -- a direction must repeat
// on two consecutive ticks before it is acted upon.
module ball_mover
  import ball_pkg::*;
#(
  parameter int CLK_FREQUENCY_HZ       = 100000000,
  parameter int UPDATE_FREQUENCY_HZ    = 5,
  parameter int SIMULATE               = 0,
  parameter int SIMULATE_FREQUENCY_CNT = 5,
  parameter int ACCEL_WIDTH            = 8,
  parameter int POS_WIDTH              = 8,
  parameter int THRESH_HI              = 192,
  parameter int THRESH_LO              = 64,
  parameter int X_MAX                  = 79,
  parameter int Y_MAX                  = 59,
  parameter int X_START                = 1,
  parameter int Y_START                = 1,
  parameter int WALL_CODE              = WALL_CODE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ACCEL_WIDTH-1:0] accel_x,
  input  logic [ACCEL_WIDTH-1:0] accel_y,
  output logic [POS_WIDTH-1:0]   wrld_col_addr,
  output logic [POS_WIDTH-1:0]   wrld_row_addr,
  input  logic [7:0]             wrld_loc_info,
  output logic [POS_WIDTH-1:0]   x_out,
  output logic [POS_WIDTH-1:0]   y_out,
  output logic                   move_valid,
  output logic                   blocked_x,
  output logic                   blocked_y,
  output logic                   busy
);

  // One extra bit so x_out-1 at zero and x_out+1 at the top both land above the limit.
  localparam int CW = POS_WIDTH + 1;
  localparam logic [CW-1:0]          X_LIM   = CW'(X_MAX);
  localparam logic [CW-1:0]          Y_LIM   = CW'(Y_MAX);
  localparam logic [POS_WIDTH-1:0]   X_INIT  = POS_WIDTH'(X_START);
  localparam logic [POS_WIDTH-1:0]   Y_INIT  = POS_WIDTH'(Y_START);
  localparam logic [7:0]             WALL_V  = 8'(WALL_CODE);
  localparam logic [ACCEL_WIDTH-1:0] HI_V    = ACCEL_WIDTH'(THRESH_HI);
  localparam logic [ACCEL_WIDTH-1:0] LO_V    = ACCEL_WIDTH'(THRESH_LO);

  logic        tick;
  ball_state_t state, next_state;
  ball_dir_t   raw_x, raw_y;
  ball_dir_t   use_x, use_y;
  ball_dir_t   dir_x, dir_y;
  logic [CW-1:0] cand_x, cand_y;
  logic        x_oob, y_oob;
  logic        x_skip, y_skip;
  logic        moved;

  ball_tick_gen #(
    .CLK_FREQUENCY_HZ      (CLK_FREQUENCY_HZ),
    .UPDATE_FREQUENCY_HZ   (UPDATE_FREQUENCY_HZ),
    .SIMULATE              (SIMULATE),
    .SIMULATE_FREQUENCY_CNT(SIMULATE_FREQUENCY_CNT)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // Threshold each tilt sample into increment / decrement / hold.
  always_comb begin
    raw_x = DIR_NONE;
    raw_y = DIR_NONE;
    if (accel_x >= HI_V)      raw_x = DIR_INC;
    else if (accel_x <= LO_V) raw_x = DIR_DEC;
    if (accel_y >= HI_V)      raw_y = DIR_INC;
    else if (accel_y <= LO_V) raw_y = DIR_DEC;
  end

`ifdef BALL_TILT_DEBOUNCE_EN
  ball_dir_t prev_x, prev_y;

  // Remember each axis direction from the previous tick for the debounce compare.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_x <= DIR_NONE;
      prev_y <= DIR_NONE;
    end else if (tick) begin
      prev_x <= raw_x;
      prev_y <= raw_y;
    end
  end

  assign use_x = debounce_dir(raw_x, prev_x);
  assign use_y = debounce_dir(raw_y, prev_y);
`else
  assign use_x = raw_x;
  assign use_y = raw_y;
`endif

  // Candidate coordinates and the out-of-range / nothing-to-do decisions per axis.
  always_comb begin
    cand_x = {1'b0, x_out};
    cand_y = {1'b0, y_out};
    if (dir_x == DIR_INC)      cand_x = {1'b0, x_out} + CW'(1);
    else if (dir_x == DIR_DEC) cand_x = {1'b0, x_out} - CW'(1);
    if (dir_y == DIR_INC)      cand_y = {1'b0, y_out} + CW'(1);
    else if (dir_y == DIR_DEC) cand_y = {1'b0, y_out} - CW'(1);
    x_oob  = (cand_x > X_LIM);
    y_oob  = (cand_y > Y_LIM);
    x_skip = (dir_x == DIR_NONE) || x_oob;
    y_skip = (dir_y == DIR_NONE) || y_oob;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: X probe/check, then Y probe/check, skipping idle axes.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (tick) next_state = PROBE_X;
      PROBE_X: next_state = x_skip ? PROBE_Y : CHECK_X;
      CHECK_X: next_state = PROBE_Y;
      PROBE_Y: next_state = y_skip ? IDLE : CHECK_Y;
      CHECK_Y: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Map address: current position, or the candidate held from PROBE through CHECK.
  always_comb begin
    wrld_col_addr = x_out;
    wrld_row_addr = y_out;
    if ((state == PROBE_X || state == CHECK_X) && !x_skip) begin
      wrld_col_addr = cand_x[POS_WIDTH-1:0];
    end
    if ((state == PROBE_Y || state == CHECK_Y) && !y_skip) begin
      wrld_row_addr = cand_y[POS_WIDTH-1:0];
    end
  end

  assign busy = (state != IDLE);

  // Position, blocked flags and the move pulse; updated only as the FSM walks the axes.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_out      <= X_INIT;
      y_out      <= Y_INIT;
      move_valid <= 1'b0;
      blocked_x  <= 1'b0;
      blocked_y  <= 1'b0;
      moved      <= 1'b0;
      dir_x      <= DIR_NONE;
      dir_y      <= DIR_NONE;
    end else begin
      move_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            dir_x <= use_x;
            dir_y <= use_y;
            moved <= 1'b0;
          end
        end
        PROBE_X: begin
          if (dir_x == DIR_NONE) blocked_x <= 1'b0;
          else if (x_oob)        blocked_x <= 1'b1;
        end
        CHECK_X: begin
          if (wrld_loc_info == WALL_V) begin
            blocked_x <= 1'b1;
          end else begin
            x_out     <= cand_x[POS_WIDTH-1:0];
            blocked_x <= 1'b0;
            moved     <= 1'b1;
          end
        end
        PROBE_Y: begin
          if (dir_y == DIR_NONE) blocked_y <= 1'b0;
          else if (y_oob)        blocked_y <= 1'b1;
          if (y_skip) move_valid <= moved;
        end
        CHECK_Y: begin
          if (wrld_loc_info == WALL_V) begin
            blocked_y  <= 1'b1;
            move_valid <= moved;
          end else begin
            y_out      <= cand_y[POS_WIDTH-1:0];
            blocked_y  <= 1'b0;
            move_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_mover.sv
// Testbench for ball_mover: directed tilt vectors, one per update tick,
// with a small map model holding a single wall cell. Expected results go
// into a scoreboard queue; a monitor pops and compares at each sequence end.
module tb_ball_mover;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] accel_x = 8'd128;
  logic [7:0] accel_y = 8'd128;
  logic [7:0] wrld_col_addr, wrld_row_addr;
  logic [7:0] wrld_loc_info = 8'd0;
  logic [7:0] x_out, y_out;
  logic       move_valid, blocked_x, blocked_y, busy;

  typedef struct {
    int ax, ay, wc, wr, ex, ey, bx, by, mv, ypc, ypr;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  vec_t e;

  int n_checks = 0;
  int n_fail   = 0;
  int wall_col = 255;
  int wall_row = 255;
  logic [7:0] floor_code = 8'd0;
  logic monitor_en = 1'b1;

  ball_mover #(
    .SIMULATE              (1),
    .SIMULATE_FREQUENCY_CNT(5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .accel_x      (accel_x),
    .accel_y      (accel_y),
    .wrld_col_addr(wrld_col_addr),
    .wrld_row_addr(wrld_row_addr),
    .wrld_loc_info(wrld_loc_info),
    .x_out        (x_out),
    .y_out        (y_out),
    .move_valid   (move_valid),
    .blocked_x    (blocked_x),
    .blocked_y    (blocked_y),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Map model: one registered read, the only wall is at (wall_col, wall_row).
  always @(posedge clk) begin
    if (int'(wrld_col_addr) == wall_col && int'(wrld_row_addr) == wall_row)
      wrld_loc_info <= 8'd2;
    else
      wrld_loc_info <= floor_code;
  end

  function automatic vec_t mk(int ax, int ay, int wc, int wr, int ex, int ey,
                              int bx, int by, int mv, int ypc, int ypr);
    vec_t v;
    v.ax = ax; v.ay = ay; v.wc = wc; v.wr = wr; v.ex = ex; v.ey = ey;
    v.bx = bx; v.by = by; v.mv = mv; v.ypc = ypc; v.ypr = ypr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    accel_x    = 8'(v.ax);
    accel_y    = 8'(v.ay);
    wall_col   = v.wc;
    wall_row   = v.wr;
    floor_code = (idx % 2 == 1) ? 8'd1 : 8'd0;
    exp_q.push_back(v);
  endtask

  task automatic waitSeqEnd(output bit done);
    bit seen_busy;
    seen_busy = 0;
    done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy) seen_busy = 1;
      else if (seen_busy) begin
        done = 1;
        return;
      end
    end
    checkOutput("sequence_timeout", 0, 1);
  endtask

  // Monitor: tracks the Y probe address and scores each completed sequence.
  logic       busy_prev = 1'b0;
  logic       yp_seen = 1'b0;
  logic [7:0] yp_col = 8'd0, yp_row = 8'd0;
  logic       mv_pending = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      busy_prev  = 1'b0;
      mv_pending = 1'b0;
    end else begin
      if (busy && !busy_prev) yp_seen = 1'b0;
      if (busy && wrld_row_addr != y_out) begin
        yp_seen = 1'b1;
        yp_col  = wrld_col_addr;
        yp_row  = wrld_row_addr;
      end
      if (!busy && busy_prev && monitor_en) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_sequence", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("x_out", int'(x_out), e.ex);
          checkOutput("y_out", int'(y_out), e.ey);
          checkOutput("blocked_x", int'(blocked_x), e.bx);
          checkOutput("blocked_y", int'(blocked_y), e.by);
          checkOutput("move_valid", int'(move_valid), e.mv);
          checkOutput("y_probe_issued", int'(yp_seen), (e.ypc != 255) ? 1 : 0);
          if (e.ypc != 255 && yp_seen) begin
            checkOutput("y_probe_col", int'(yp_col), e.ypc);
            checkOutput("y_probe_row", int'(yp_row), e.ypr);
          end
          mv_pending = move_valid;
        end
      end else if (mv_pending) begin
        checkOutput("move_valid_single_cycle", int'(move_valid), 0);
        mv_pending = 1'b0;
      end
      busy_prev = busy;
    end
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit done;
    int n;

    // ax, ay, wall col/row, exp x, y, bx, by, mv, y-probe col/row (255 = none)
`ifdef BALL_TILT_DEBOUNCE_EN
    vecs.push_back(mk(200, 128, 255, 255, 1, 1, 0, 0, 0, 255, 255));
    vecs.push_back(mk(200, 128, 255, 255, 2, 1, 0, 0, 1, 255, 255));
    vecs.push_back(mk(128,  10, 255, 255, 2, 1, 0, 0, 0, 255, 255));
    vecs.push_back(mk(128,  10, 255, 255, 2, 0, 0, 0, 1,   2,   0));
    vecs.push_back(mk(128,  10, 255, 255, 2, 0, 0, 1, 0, 255, 255));
    vecs.push_back(mk(200, 128,   3,   0, 2, 0, 0, 0, 0, 255, 255));
`else
    vecs.push_back(mk(200, 128,   2,   1, 1, 1, 1, 0, 0, 255, 255));
    vecs.push_back(mk(200, 128, 255, 255, 2, 1, 0, 0, 1, 255, 255));
    vecs.push_back(mk(128,  10, 255, 255, 2, 0, 0, 0, 1,   2,   0));
    vecs.push_back(mk(128,  10, 255, 255, 2, 0, 0, 1, 0, 255, 255));
    vecs.push_back(mk(200, 200, 255, 255, 3, 1, 0, 0, 1,   3,   1));
    vecs.push_back(mk( 10, 128,   2,   1, 3, 1, 1, 0, 0, 255, 255));
    vecs.push_back(mk( 64, 192, 255, 255, 2, 2, 0, 0, 1,   2,   2));
    vecs.push_back(mk( 65, 191, 255, 255, 2, 2, 0, 0, 0, 255, 255));
    vecs.push_back(mk(128, 200,   2,   3, 2, 2, 0, 1, 0,   2,   3));
    vecs.push_back(mk(  0, 255,   1,   2, 2, 3, 1, 0, 1,   2,   3));
`endif
    n = vecs.size();

    $display("[TB] reset phase");
    repeat (3) @(negedge clk);
    checkOutput("reset_x_out", int'(x_out), 1);
    checkOutput("reset_y_out", int'(y_out), 1);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_move_valid", int'(move_valid), 0);
    checkOutput("reset_blocked_x", int'(blocked_x), 0);
    checkOutput("reset_blocked_y", int'(blocked_y), 0);
    checkOutput("reset_col_addr", int'(wrld_col_addr), 1);
    checkOutput("reset_row_addr", int'(wrld_row_addr), 1);

    applyStimulus(vecs[0], 0);
    reset = 1'b0;
    $display("[TB] directed vectors: %0d", n);
    for (int i = 0; i < n; i++) begin
      waitSeqEnd(done);
      if (!done) break;
      if (i + 1 < n) applyStimulus(vecs[i + 1], i + 1);
    end

    // Abort a sequence in CHECK_X with reset; nothing may be committed.
    @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    monitor_en = 1'b0;
    accel_x  = 8'd200;
    accel_y  = 8'd128;
    wall_col = 255;
    wall_row = 255;
    done = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy) begin
        done = 1;
        break;
      end
    end
    checkOutput("abort_sequence_started", int'(done), 1);
    @(negedge clk);
    checkOutput("abort_busy_in_check_x", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_x_out", int'(x_out), 1);
    checkOutput("abort_y_out", int'(y_out), 1);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_move_valid", int'(move_valid), 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_abort_move_valid", int'(move_valid), 0);
    checkOutput("post_abort_x_out", int'(x_out), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
